// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and small decode helpers for the RAM slave.
// Address-phase legality and byte-lane selection live here so the top stays focused on the FSM.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE   = 3'd0,
    HSIZE_HALF   = 3'd1,
    HSIZE_WORD   = 3'd2,
    HSIZE_DWORD  = 3'd3,
    HSIZE_4WORD  = 3'd4,
    HSIZE_8WORD  = 3'd5,
    HSIZE_16WORD = 3'd6,
    HSIZE_32WORD = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ERR1   = 3'd3,
    ST_ERR2   = 3'd4
  } slave_state_e;

  // Sizes wider than a word are never legal on this 32-bit slave.
  function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: size_aligned = 1'b1;
      HSIZE_HALF: size_aligned = ~addr_lo[0];
      HSIZE_WORD: size_aligned = (addr_lo == 2'b00);
      default:    size_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_ram_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
// A read that lands on the word being written in the same cycle sees the merged new contents.
module ahb_ram_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [3:0]       wmask,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] read_word;

  // Contents are deliberately left out of reset.
  always_ff @(posedge hclk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    read_word = mem[raddr];
    if (we && (waddr == raddr)) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          read_word[8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= read_word;
    end
  end

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite slave front end for an on-chip RAM: address decode, wait-state
// sequencing and the two-cycle ERROR response wrapped around ahb_ram_array.
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h1000_0000,
  parameter int                    MEM_DEPTH   = 1024,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic [1:0]            hresp
);

  localparam int                    IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [2:0]            WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  slave_state_e          state;
  slave_state_e          next_state;
  logic [2:0]            wait_cnt;
  logic [2:0]            wait_cnt_next;
  logic [ADDR_WIDTH-1:0] addr_offset;
  logic                  addr_ok;
  logic                  legal;
  logic                  accept;
  logic [IDX_W-1:0]      idx_q;
  logic [3:0]            mask_q;
  logic                  write_q;
  logic                  mem_we;
  logic                  mem_re;
  logic                  unused_bits;

  // Unsigned wrap makes addresses below the base land far out of range.
  assign addr_offset = haddr - BASE_ADDR;
  assign legal       = (addr_offset < MEM_BYTES) && size_aligned(hsize, haddr[1:0]);
  assign addr_ok     = hsel && htrans[1];
  assign accept      = hready && addr_ok;

  assign mem_we = (state == ST_ACCESS) && write_q;
  assign mem_re = accept && legal && !hwrite;

  assign unused_bits = ^{hburst, htrans[0]};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Only states that drive hready high may sample a new address phase.
  always_comb begin
    next_state    = state;
    wait_cnt_next = wait_cnt;
    hready        = 1'b1;
    hresp         = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_ACCESS, ST_ERR2: begin
        if (state == ST_ERR2) begin
          hresp = HRESP_ERROR;
        end
        next_state = ST_IDLE;
        if (addr_ok) begin
          if (!legal) begin
            next_state = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            next_state    = ST_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            next_state = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        hready = 1'b0;
        if (wait_cnt == 3'd0) begin
          next_state = ST_ACCESS;
        end else begin
          wait_cnt_next = wait_cnt - 3'd1;
        end
      end
      ST_ERR1: begin
        hready     = 1'b0;
        hresp      = HRESP_ERROR;
        next_state = ST_ERR2;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      idx_q   <= '0;
      mask_q  <= 4'b0000;
      write_q <= 1'b0;
    end else if (accept && legal) begin
      idx_q   <= addr_offset[IDX_W+1:2];
      mask_q  <= lane_mask(hsize, haddr[1:0]);
      write_q <= hwrite;
    end
  end

  ahb_ram_array #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .hclk    (hclk),
    .hresetn (hresetn),
    .we      (mem_we),
    .waddr   (idx_q),
    .wmask   (mask_q),
    .wdata   (hwdata),
    .re      (mem_re),
    .raddr   (addr_offset[IDX_W+1:2]),
    .rdata   (hrdata)
  );

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Bench for ahb_ram_slave: two instances (0 and 2 wait states) on a shared bus,
// directed scenarios plus random traffic checked against a byte-addressed memory model.
module tb_ahb_ram_slave;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        sel0;
  logic        sel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        ready0;
  logic        ready1;
  logic [1:0]  resp0;
  logic [1:0]  resp1;

  int passed = 0;
  int total  = 0;

  logic [7:0] model0 [int unsigned];
  logic [7:0] model1 [int unsigned];

  always #5 hclk = ~hclk;

  ahb_ram_slave #(.WAIT_STATES(0)) dut0 (
    .hclk (hclk), .hresetn (hresetn), .hsel (sel0), .haddr (haddr),
    .htrans (htrans), .hwrite (hwrite), .hsize (hsize), .hburst (hburst),
    .hwdata (hwdata), .hrdata (rdata0), .hready (ready0), .hresp (resp0)
  );

  ahb_ram_slave #(.WAIT_STATES(2)) dut1 (
    .hclk (hclk), .hresetn (hresetn), .hsel (sel1), .haddr (haddr),
    .htrans (htrans), .hwrite (hwrite), .hsize (hsize), .hburst (hburst),
    .hwdata (hwdata), .hrdata (rdata1), .hready (ready1), .hresp (resp1)
  );

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] rd_of(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  function automatic logic rdy_of(input int d);
    return (d == 0) ? ready0 : ready1;
  endfunction

  function automatic logic [1:0] resp_of(input int d);
    return (d == 0) ? resp0 : resp1;
  endfunction

  function automatic int waits_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Byte-granular model: an access of 2**size bytes touches exactly those byte addresses.
  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] data);
    for (int k = 0; k < (1 << sz); k++) begin
      int unsigned ba;
      logic [31:0] sh;
      ba = a + k;
      sh = data >> (8 * (ba % 4));
      if (d == 0) model0[ba] = sh[7:0];
      else        model1[ba] = sh[7:0];
    end
  endtask

  task automatic model_word(input int d, input logic [31:0] a, output logic [31:0] w,
                            output logic known);
    int unsigned wa;
    wa = a - (a % 4);
    w = '0;
    known = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (d == 0 && model0.exists(wa + k))      w[8*k +: 8] = model0[wa + k];
      else if (d == 1 && model1.exists(wa + k)) w[8*k +: 8] = model1[wa + k];
      else                                      known = 1'b0;
    end
  endtask

  task automatic bus_idle();
    sel0 = 1'b0; sel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    haddr = '0; hsize = 3'd2; hburst = 3'd0;
  endtask

  task automatic apply_stimulus(input int d, input logic [31:0] a, input logic wr,
                                input logic [2:0] sz, input logic [1:0] tr, input logic [2:0] bu);
    sel0 = (d == 0); sel1 = (d == 1); haddr = a; hwrite = wr;
    hsize = sz; htrans = tr; hburst = bu;
  endtask

  // Single NONSEQ transfer followed by IDLE; starts and ends 1 time unit after a posedge.
  task automatic xfer(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int stalls,
                      output logic [1:0] first_resp, output logic [1:0] last_resp);
    logic done;
    apply_stimulus(d, a, wr, sz, 2'b10, 3'd0);
    @(posedge hclk); #1;
    bus_idle();
    hwdata = wdata;
    stalls = 0; done = 1'b0;
    first_resp = 2'b11; last_resp = 2'b11; rdata = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge hclk);
      if (c == 0) first_resp = resp_of(d);
      if (rdy_of(d)) begin
        done = 1'b1;
        last_resp = resp_of(d);
        rdata = rd_of(d);
        break;
      end
      stalls++;
    end
    check("data phase completes", {31'b0, done}, 32'd1);
    @(posedge hclk); #1;
  endtask

  task automatic check_output(input int d, input logic [31:0] a, input logic wr,
                              input logic [2:0] sz, input logic [31:0] wdata,
                              input string tag, output logic [31:0] rdata);
    logic legal;
    logic known;
    logic [31:0] exp_w;
    int stalls;
    logic [1:0] r_first;
    logic [1:0] r_last;
    legal = ((a - BASE) < DEPTH * 4) && (sz <= 3'd2) && ((a % (1 << sz)) == 0);
    xfer(d, a, wr, sz, wdata, rdata, stalls, r_first, r_last);
    if (legal) begin
      check({tag, " stalls"}, 32'(stalls), 32'(waits_of(d)));
      check({tag, " resp"}, {30'b0, r_last}, 32'd0);
      if (wr) begin
        model_write(d, a, sz, wdata);
      end else begin
        model_word(d, a, exp_w, known);
        if (known) check({tag, " rdata"}, rdata, exp_w);
      end
    end else begin
      check({tag, " err stalls"}, 32'(stalls), 32'd1);
      check({tag, " err resp1"}, {30'b0, r_first}, 32'd1);
      check({tag, " err resp2"}, {30'b0, r_last}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] burst_data [4];
    int low;
    logic done;

    hresetn = 1'b0;
    hwdata  = '0;
    bus_idle();
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    check("reset hready0", {31'b0, ready0}, 32'd1);
    check("reset hresp0", {30'b0, resp0}, 32'd0);
    check("reset hrdata0", rdata0, 32'd0);
    check("reset hready1", {31'b0, ready1}, 32'd1);
    check("reset hresp1", {30'b0, resp1}, 32'd0);
    check("reset hrdata1", rdata1, 32'd0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    $display("[TB] word write/read");
    check_output(0, BASE, 1'b1, 3'd2, 32'hDEAD_BEEF, "wr deadbeef", r);
    check_output(0, BASE, 1'b0, 3'd2, 32'h0, "rd deadbeef", r);
    check("deadbeef value", r, 32'hDEAD_BEEF);

    $display("[TB] byte lane write");
    check_output(0, BASE + 32'h4, 1'b1, 3'd2, 32'h1122_3344, "wr 11223344", r);
    check_output(0, BASE + 32'h6, 1'b1, 3'd0, 32'h00AA_0000, "wr byte aa", r);
    check_output(0, BASE + 32'h4, 1'b0, 3'd2, 32'h0, "rd merged", r);
    check("byte merge value", r, 32'h11AA_3344);

    $display("[TB] error responses");
    check_output(0, 32'h2000_0000, 1'b1, 3'd2, 32'h1234_5678, "wr out of range", r);
    check_output(0, BASE + 32'h2, 1'b1, 3'd2, 32'h8765_4321, "wr misaligned", r);
    check_output(0, BASE, 1'b0, 3'd2, 32'h0, "rd after error", r);
    check("unchanged after error", r, 32'hDEAD_BEEF);

    $display("[TB] back-to-back write then read");
    apply_stimulus(0, BASE + 32'h20, 1'b1, 3'd2, 2'b10, 3'd0);
    @(posedge hclk); #1;
    apply_stimulus(0, BASE + 32'h20, 1'b0, 3'd2, 2'b10, 3'd0);
    hwdata = 32'hFACE_FEED;
    @(negedge hclk);
    check("b2b write hready", {31'b0, ready0}, 32'd1);
    check("b2b write hresp", {30'b0, resp0}, 32'd0);
    @(posedge hclk); #1;
    bus_idle();
    @(negedge hclk);
    check("b2b read hready", {31'b0, ready0}, 32'd1);
    check("b2b read forward", rdata0, 32'hFACE_FEED);
    @(posedge hclk); #1;
    model_write(0, BASE + 32'h20, 3'd2, 32'hFACE_FEED);

    $display("[TB] INCR4 with wait states");
    for (int i = 0; i < 4; i++) burst_data[i] = $urandom;
    apply_stimulus(1, BASE + 32'h10, 1'b1, 3'd2, 2'b10, 3'd3);
    @(posedge hclk); #1;
    for (int i = 0; i < 4; i++) begin
      hwdata = burst_data[i];
      if (i < 3) apply_stimulus(1, BASE + 32'h10 + 32'(4 * (i + 1)), 1'b1, 3'd2, 2'b11, 3'd3);
      else       bus_idle();
      low = 0; done = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge hclk);
        check("incr4 hresp", {30'b0, resp1}, 32'd0);
        if (ready1) begin
          done = 1'b1;
          break;
        end
        low++;
      end
      check("incr4 beat done", {31'b0, done}, 32'd1);
      check("incr4 wait cycles", 32'(low), 32'd2);
      @(posedge hclk); #1;
      model_write(1, BASE + 32'h10 + 32'(4 * i), 3'd2, burst_data[i]);
    end
    for (int i = 0; i < 4; i++) begin
      check_output(1, BASE + 32'h10 + 32'(4 * i), 1'b0, 3'd2, 32'h0, "incr4 readback", r);
      check("incr4 word", r, burst_data[i]);
    end

    $display("[TB] reset during wait state");
    check_output(1, BASE + 32'h30, 1'b1, 3'd2, 32'h0BAD_C0DE, "wr old", r);
    apply_stimulus(1, BASE + 32'h30, 1'b1, 3'd2, 2'b10, 3'd0);
    @(posedge hclk); #1;
    bus_idle();
    hwdata = 32'h5555_AAAA;
    @(negedge hclk);
    check("pre-reset hready low", {31'b0, ready1}, 32'd0);
    #2;
    hresetn = 1'b0;
    #1;
    check("async reset hready", {31'b0, ready1}, 32'd1);
    check("async reset hresp", {30'b0, resp1}, 32'd0);
    check("async reset hrdata", rdata1, 32'd0);
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    check_output(1, BASE + 32'h30, 1'b0, 3'd2, 32'h0, "rd after reset", r);
    check("aborted write not committed", r, 32'h0BAD_C0DE);

    $display("[TB] random traffic");
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        check_output(d, BASE + 32'h100 + 32'(4 * w), 1'b1, 3'd2, $urandom, "rand init", r);
      end
    end
    for (int n = 0; n < 80; n++) begin
      int d;
      int kind;
      logic wr;
      logic [2:0] sz;
      logic [31:0] off;
      logic [31:0] a;
      d    = $urandom_range(0, 1);
      wr   = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 2));
      off  = 32'($urandom_range(0, 63));
      off  = off & ~((32'd1 << sz) - 32'd1);
      a    = BASE + 32'h100 + off;
      kind = $urandom_range(0, 9);
      if (kind == 0)                   a = BASE + 32'(DEPTH * 4) + off;
      else if (kind == 1)              a = BASE - 32'd4;
      else if (kind == 2)              sz = 3'($urandom_range(3, 7));
      else if (kind == 3 && sz != 3'd0) a = a | 32'd1;
      check_output(d, a, wr, sz, $urandom, "rand", r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
